// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-to-one AXI-lite arbiter.
package axi_lite_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Arbiter phase: waiting for a request, or owning one write or one read downstream.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_RD   = 2'b10
    } state_e;

endpackage

// File: rtl/axi_lite_arbiter_2to1_if.sv
// One AXI-lite link: all five channels, seen from either end via modports.
interface axi_lite_if
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1_rr_arb2.sv
// Two-way round-robin pointer and winner selection.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       owner_i,
    output logic       grant_o
);
    logic lastOwner_q;

    // Remember who finished last; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastOwner_q <= 1'b1;
        end else if (update_i) begin
            lastOwner_q <= owner_i;
        end
    end

    // On a tie pick whoever did not go last; otherwise pick the lone requester.
    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = ~lastOwner_q;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end
endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI-lite register slave between two requesters, one transaction at a time.
module axi_lite_arbiter_2to1
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_lite_if.slave   s0,
    axi_lite_if.slave   s1,
    axi_lite_if.master  m,
    output logic [1:0]  gnt
);
    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   awDone_q, awDone_d;
    logic   wDone_q, wDone_d;
    logic   arDone_q, arDone_d;
    logic   txnEnd;
    logic   winner;
    logic [1:0] anyReq;
    logic [1:0] wrReq;

    logic [ADDR_W-1:0]   ownAwaddr, ownAraddr;
    logic [DATA_W-1:0]   ownWdata;
    logic [DATA_W/8-1:0] ownWstrb;
    logic ownAwvalid, ownWvalid, ownBready, ownArvalid, ownRready;
    logic upAwready, upWready, upBvalid, upArready, upRvalid;

    assign wrReq  = {s1.awvalid, s0.awvalid};
    assign anyReq = {s1.awvalid | s1.arvalid, s0.awvalid | s0.arvalid};
    assign gnt    = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (anyReq),
        .update_i (txnEnd),
        .owner_i  (owner_q),
        .grant_o  (winner)
    );

    // Select the current owner's request-side signals.
    always_comb begin
        ownAwaddr  = owner_q ? s1.awaddr  : s0.awaddr;
        ownAwvalid = owner_q ? s1.awvalid : s0.awvalid;
        ownWdata   = owner_q ? s1.wdata   : s0.wdata;
        ownWstrb   = owner_q ? s1.wstrb   : s0.wstrb;
        ownWvalid  = owner_q ? s1.wvalid  : s0.wvalid;
        ownBready  = owner_q ? s1.bready  : s0.bready;
        ownAraddr  = owner_q ? s1.araddr  : s0.araddr;
        ownArvalid = owner_q ? s1.arvalid : s0.arvalid;
        ownRready  = owner_q ? s1.rready  : s0.rready;
    end

    // State, owner and per-channel done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            arDone_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
            arDone_q <= arDone_d;
        end
    end

    // Grant in IDLE, track address/data handshakes, and release on the response handshake.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        awDone_d = awDone_q;
        wDone_d  = wDone_q;
        arDone_d = arDone_q;
        txnEnd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|anyReq) begin
                    owner_d = winner;
                    state_d = wrReq[winner] ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (ownAwvalid && !awDone_q && m.awready) awDone_d = 1'b1;
                if (ownWvalid && !wDone_q && m.wready)    wDone_d  = 1'b1;
                if (m.bvalid && ownBready) begin
                    state_d  = ST_IDLE;
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    txnEnd   = 1'b1;
                end
            end
            ST_RD: begin
                if (ownArvalid && !arDone_q && m.arready) arDone_d = 1'b1;
                if (m.rvalid && ownRready) begin
                    state_d  = ST_IDLE;
                    arDone_d = 1'b0;
                    txnEnd   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forward the owner's channels downstream; valids depend only on owner inputs and done flags.
    always_comb begin
        m.awaddr  = '0;
        m.awvalid = 1'b0;
        m.wdata   = '0;
        m.wstrb   = '0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        m.araddr  = '0;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;
        upAwready = 1'b0;
        upWready  = 1'b0;
        upBvalid  = 1'b0;
        upArready = 1'b0;
        upRvalid  = 1'b0;
        case (state_q)
            ST_WR: begin
                m.awaddr  = ownAwaddr;
                m.awvalid = ownAwvalid & ~awDone_q;
                m.wdata   = ownWdata;
                m.wstrb   = ownWstrb;
                m.wvalid  = ownWvalid & ~wDone_q;
                m.bready  = ownBready;
                upAwready = m.awready & ~awDone_q;
                upWready  = m.wready & ~wDone_q;
                upBvalid  = m.bvalid;
            end
            ST_RD: begin
                m.araddr  = ownAraddr;
                m.arvalid = ownArvalid & ~arDone_q;
                m.rready  = ownRready;
                upArready = m.arready & ~arDone_q;
                upRvalid  = m.rvalid;
            end
            default: ;
        endcase
    end

    assign s0.awready = gnt[0] & upAwready;
    assign s0.wready  = gnt[0] & upWready;
    assign s0.bvalid  = gnt[0] & upBvalid;
    assign s0.bresp   = gnt[0] ? m.bresp : 2'b00;
    assign s0.arready = gnt[0] & upArready;
    assign s0.rvalid  = gnt[0] & upRvalid;
    assign s0.rdata   = gnt[0] ? m.rdata : '0;
    assign s0.rresp   = gnt[0] ? m.rresp : 2'b00;

    assign s1.awready = gnt[1] & upAwready;
    assign s1.wready  = gnt[1] & upWready;
    assign s1.bvalid  = gnt[1] & upBvalid;
    assign s1.bresp   = gnt[1] ? m.bresp : 2'b00;
    assign s1.arready = gnt[1] & upArready;
    assign s1.rvalid  = gnt[1] & upRvalid;
    assign s1.rdata   = gnt[1] ? m.rdata : '0;
    assign s1.rresp   = gnt[1] ? m.rresp : 2'b00;
endmodule

// File: doc/axi_lite_arbiter_2to1.md
AXI_LITE_ARBITER_2TO1 -- requirements
Module: axi_lite_arbiter_2to1

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width of every address channel.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have, for each requester k in {0,1}, the following upstream AXI-lite slave-side bundles, SHALL statements REQ-006 to REQ-010.
REQ-006 sk_awaddr/sk_awvalid  input  ADDR_W/1, and sk_awready  output  1  write address channel.
REQ-007 sk_wdata/sk_wstrb/sk_wvalid  input  DATA_W/DATA_W/8/1, and sk_wready  output  1  write data channel.
REQ-008 sk_bresp/sk_bvalid  output  2/1, and sk_bready  input  1  write response channel.
REQ-009 sk_araddr/sk_arvalid  input  ADDR_W/1, and sk_arready  output  1  read address channel.
REQ-010 sk_rdata/sk_rresp/sk_rvalid  output  DATA_W/2/1, and sk_rready  input  1  read data channel.
REQ-011 The block SHALL have the mirror downstream bundle m_aw*, m_w*, m_b*, m_ar*, m_r* (same widths, opposite directions) toward the shared register slave.
REQ-012 The block SHALL have port gnt  output  2  one-hot current owner, 2'b00 when idle.

Function
REQ-013 State machine SHALL have states IDLE, WR, RD; exactly one transaction outstanding downstream at any time.
REQ-014 Requests: write request of k = sk_awvalid; read request of k = sk_arvalid; within one requester, write SHALL win over read.
REQ-015 In IDLE with requests from both requesters, grant SHALL go to the requester not equal to last_owner (round-robin); with one requester, grant goes to it.
REQ-016 Grant decision SHALL be registered: request seen in IDLE at edge N -> state WR/RD and gnt valid from cycle N+1; no downstream valid in IDLE.
REQ-017 In WR, m_awvalid = sk_awvalid & ~aw_done, sk_awready = m_awready & ~aw_done; W channel likewise with w_done; addr/data/strb forwarded combinationally from owner.
REQ-018 aw_done/w_done SHALL set on respective downstream handshake, independently, in either order or same cycle.
REQ-019 In WR, m_bready = sk_bready and sk_bvalid = m_bvalid for the owner only; B handshake SHALL return to IDLE, clear done flags, update last_owner.
REQ-020 In RD, AR forwarded with ar_done gating as REQ-017; R channel forwarded to owner only; R handshake returns to IDLE, updates last_owner.
REQ-021 Non-owner requester SHALL see all ready and valid outputs at 0; its inputs SHALL be ignored and held by it (AXI valid stability).
REQ-022 Responses (bresp, rresp, rdata) SHALL pass through unmodified, including SLVERR and error data from the slave.
REQ-023 Downstream address/data outputs SHALL be 0 in IDLE; no combinational path from m_*ready to m_*valid.
REQ-024 Back-to-back: request pending at the cycle the ending handshake completes SHALL be arbitrated in the following IDLE cycle (one idle cycle between transactions).

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, done flags=0, last_owner=1 (requester 0 wins first tie), gnt=0, every valid/ready output 0.
REQ-026 Reset mid-transaction SHALL abandon it without completion; requesters and slave are reset together.

Structure
REQ-027 Package axi_lite_arb_pkg SHALL hold the state enum, resp constants (OKAY 2'b00, SLVERR 2'b10) and default widths.
REQ-028 Round-robin pointer and grant selection SHALL be one sub-module, rr_arb2; channel muxing stays in the top.

Verification (downstream = axi_lite_slave_regs, REG_NUM=4)
REQ-029 s0 writes 0xA5A50000 to 0x0 alone -> gnt=01 next cycle, bresp=OKAY to s0, s1 sees no bvalid; s0 read 0x0 returns 0xA5A50000.
REQ-030 s0 and s1 assert awvalid same cycle (addr 0x4 data 0x11, addr 0x8 data 0x22) -> s0 served first, s1 next, then reads return 0x11, 0x22.
REQ-031 Both requesters issue 4 continuous writes -> grants alternate 0,1,0,1...; no requester starved >1 transaction.
REQ-032 s1 drives wvalid 3 cycles before awvalid -> no downstream W until grant; single write completes, bresp OKAY.
REQ-033 s0 reads invalid 0x20 while s1 writes 0xC -> s0 gets 0xDEADBEEF with slave rresp unmodified; s1 write completes.
REQ-034 rst_n low during WR after AW handshake -> all valids/readies 0 immediately, gnt=00, next request after release granted to s0.
